// File: rtl/mem_dual_arbiter.sv
// Serialises the master/slave accesses of one dual-issue pair onto a single SRAM-like bus.
// Define MEM_LLBIT_EN to enable the LL/SC link bit; otherwise every SC succeeds.
`timescale 1ns/1ps
module mem_dual_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          m_req,
  input  logic          s_req,
  input  logic [3:0]    m_wen,
  input  logic [3:0]    s_wen,
  input  logic [1:0]    m_size,
  input  logic [1:0]    s_size,
  input  logic [AW-1:0] m_addr,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] s_wdata,
  input  logic          m_ll,
  input  logic          s_ll,
  input  logic          m_sc,
  input  logic          s_sc,
  input  logic          flush,
  input  logic          llbit_clr,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [3:0]    data_wstrb,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata,
  output logic [DW-1:0] m_rdata,
  output logic [DW-1:0] s_rdata,
  output logic          m_sc_ok,
  output logic          s_sc_ok,
  output logic          mem_stall
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  state_e        state_q;
  logic          cur_q;
  logic          drop_q;
  logic [DW-1:0] m_rdata_q;
  logic [DW-1:0] s_rdata_q;
  logic          m_sc_ok_q;
  logic          s_sc_ok_q;

  logic cur_sc;
  logic llbit;
  logic sc_fail;
  logic capture;
  logic to_slave;

  // Bus fields always follow the selected slot; only data_req qualifies them.
  assign data_wstrb = cur_q ? s_wen   : m_wen;
  assign data_size  = cur_q ? s_size  : m_size;
  assign data_addr  = cur_q ? s_addr  : m_addr;
  assign data_wdata = cur_q ? s_wdata : m_wdata;
  assign data_wr    = |data_wstrb;

  assign cur_sc    = cur_q ? s_sc : m_sc;
  assign sc_fail   = cur_sc & ~llbit;
  assign data_req  = (state_q == ADDR) & ~sc_fail;
  assign capture   = (state_q == DATA) & data_data_ok & ~drop_q & ~flush;
  assign to_slave  = ~cur_q & s_req;
  assign mem_stall = (m_req | s_req) & (state_q != DONE);

  assign m_rdata = m_rdata_q;
  assign s_rdata = s_rdata_q;
  assign m_sc_ok = m_sc_ok_q;
  assign s_sc_ok = s_sc_ok_q;

`ifdef MEM_LLBIT_EN
  logic llbit_q;
  logic cur_ll;

  assign cur_ll = cur_q ? s_ll : m_ll;
  assign llbit  = llbit_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      llbit_q <= 1'b0;
    end else if (flush || llbit_clr) begin
      llbit_q <= 1'b0;
    end else if (capture) begin
      llbit_q <= cur_sc ? 1'b0 : (cur_ll | llbit_q);
    end
  end
`else
  logic [2:0] unused_ll;

  assign unused_ll = {m_ll, s_ll, llbit_clr};
  assign llbit     = 1'b1;
`endif

  // NOTE: state is updated with non-blocking assignments so every branch sees the pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cur_q     <= 1'b0;
      drop_q    <= 1'b0;
      m_rdata_q <= '0;
      s_rdata_q <= '0;
      m_sc_ok_q <= 1'b0;
      s_sc_ok_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!flush && (m_req || s_req)) begin
            state_q <= ADDR;
            cur_q   <= ~m_req;
          end
        end
        ADDR: begin
          if (sc_fail) begin
            if (flush) begin
              state_q <= IDLE;
            end else begin
              if (cur_q) s_sc_ok_q <= 1'b0;
              else       m_sc_ok_q <= 1'b0;
              state_q <= to_slave ? ADDR : DONE;
              cur_q   <= cur_q | to_slave;
            end
          end else if (data_addr_ok) begin
            // An accepted request must still be drained; flush only marks it for discard.
            state_q <= DATA;
            drop_q  <= flush;
          end else if (flush) begin
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (data_data_ok) begin
            drop_q <= 1'b0;
            if (capture) begin
              if (cur_q) begin
                if (!data_wr) s_rdata_q <= data_rdata;
                s_sc_ok_q <= cur_sc;
              end else begin
                if (!data_wr) m_rdata_q <= data_rdata;
                m_sc_ok_q <= cur_sc;
              end
              state_q <= to_slave ? ADDR : DONE;
              cur_q   <= cur_q | to_slave;
            end else begin
              state_q <= IDLE;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dual_arbiter.sv
// Self-checking bench for mem_dual_arbiter: directed table, flush/reset sequences and
// randomised instruction pairs against a cycle-count/transaction-list reference model.
`timescale 1ns/1ps
module tb_mem_dual_arbiter;

  typedef struct packed {
    logic        req;
    logic [3:0]  wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ll;
    logic        sc;
  } slot_t;

  typedef struct packed {
    slot_t       m;
    slot_t       s;
    logic [3:0]  a0;
    logic [3:0]  d0;
    logic [3:0]  a1;
    logic [3:0]  d1;
    logic [31:0] rv0;
    logic [31:0] rv1;
  } pair_t;

  typedef struct packed {
    pair_t      p;
    logic [7:0] want;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [1:0]  size;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_req, s_req;
  logic [3:0]  m_wen, s_wen;
  logic [1:0]  m_size, s_size;
  logic [31:0] m_addr, s_addr, m_wdata, s_wdata;
  logic        m_ll, s_ll, m_sc, s_sc, flush, llbit_clr;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] m_rdata, s_rdata;
  logic        m_sc_ok, s_sc_ok, mem_stall;

  int checks   = 0;
  int failures = 0;

  int          a_lat[4];
  int          d_lat[4];
  logic [31:0] rv_tab[4];
  int          bus_idx, acnt, dcnt;
  bit          pending;
  logic [31:0] cur_rv;
  txn_t        txn_q[$];
  logic        obs_req, obs_stall;

  logic [31:0] exp_rd[2];
  logic        exp_ok[2];
  logic        mdl_llbit;

  vec_t vecs[7];

  always #5 clk = ~clk;

  mem_dual_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .resetn(resetn),
    .m_req(m_req), .s_req(s_req), .m_wen(m_wen), .s_wen(s_wen),
    .m_size(m_size), .s_size(s_size), .m_addr(m_addr), .s_addr(s_addr),
    .m_wdata(m_wdata), .s_wdata(s_wdata),
    .m_ll(m_ll), .s_ll(s_ll), .m_sc(m_sc), .s_sc(s_sc),
    .flush(flush), .llbit_clr(llbit_clr),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_rdata(m_rdata), .s_rdata(s_rdata), .m_sc_ok(m_sc_ok), .s_sc_ok(s_sc_ok),
    .mem_stall(mem_stall)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic slot_t mk_slot(input logic req, input logic [3:0] wen, input logic [1:0] size,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic ll, input logic sc);
    slot_t s;
    s.req = req; s.wen = wen; s.size = size; s.addr = addr; s.wdata = wdata; s.ll = ll; s.sc = sc;
    return s;
  endfunction

  function automatic pair_t mk_pair(input slot_t m, input slot_t s, input logic [3:0] a0,
                                    input logic [3:0] d0, input logic [3:0] a1, input logic [3:0] d1,
                                    input logic [31:0] rv0, input logic [31:0] rv1);
    pair_t p;
    p.m = m; p.s = s; p.a0 = a0; p.d0 = d0; p.a1 = a1; p.d1 = d1; p.rv0 = rv0; p.rv1 = rv1;
    return p;
  endfunction

  function automatic slot_t rnd_slot(input logic req);
    slot_t s;
    s       = mk_slot(req, 4'h0, 2'($urandom_range(0, 2)), $urandom, $urandom, 1'b0, 1'b0);
    case ($urandom_range(0, 4))
      0, 1:    s.wen = 4'h0;
      2:       s.wen = 4'($urandom_range(1, 15));
      3:       s.ll  = 1'b1;
      default: begin s.wen = 4'hF; s.sc = 1'b1; end
    endcase
    return s;
  endfunction

  task automatic set_slots(input slot_t m, input slot_t s);
    m_req = m.req; m_wen = m.wen; m_size = m.size; m_addr = m.addr; m_wdata = m.wdata;
    m_ll = m.ll; m_sc = m.sc;
    s_req = s.req; s_wen = s.wen; s_size = s.size; s_addr = s.addr; s_wdata = s.wdata;
    s_ll = s.ll; s_sc = s.sc;
  endtask

  task automatic bus_setup(input int a0, input int d0, input logic [31:0] rv0);
    for (int i = 0; i < 4; i++) begin
      a_lat[i] = 0; d_lat[i] = 1; rv_tab[i] = $urandom;
    end
    a_lat[0] = a0; d_lat[0] = d0; rv_tab[0] = rv0;
    bus_idx = 0; acnt = 0;
    txn_q.delete();
  endtask

  // One clock: starts and ends at a falling edge; the bus responder lives here.
  task automatic cycle();
    int   k;
    txn_t t;
    #1;
    k = (bus_idx > 3) ? 3 : bus_idx;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
    if (pending) begin
      check("bus_req_while_busy", 128'(data_req), 128'(0));
      if (dcnt == 1) begin data_data_ok = 1'b1; data_rdata = cur_rv; end
    end else if (data_req === 1'b1 && acnt >= a_lat[k]) begin
      data_addr_ok = 1'b1;
      t.addr = data_addr; t.wr = data_wr; t.wstrb = data_wstrb; t.size = data_size; t.wdata = data_wdata;
      txn_q.push_back(t);
    end
    obs_req = data_req; obs_stall = mem_stall;
    @(posedge clk);
    if (pending) begin
      if (data_data_ok) pending = 1'b0;
      else dcnt--;
    end else if (obs_req) begin
      if (data_addr_ok) begin
        pending = 1'b1; dcnt = d_lat[k]; cur_rv = rv_tab[k]; bus_idx++; acnt = 0;
      end else begin
        acnt++;
      end
    end else begin
      acnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic run_pair(input pair_t p, input int want, input string name);
    slot_t sl[2];
    txn_t  exp_q[$];
    txn_t  t;
    int    exp_stall, ridx, stalls;
    logic  llb;
    sl[0] = p.m; sl[1] = p.s;
    bus_setup(int'(p.a0), int'(p.d0), p.rv0);
    a_lat[1] = int'(p.a1); d_lat[1] = int'(p.d1); rv_tab[1] = p.rv1;
    exp_stall = 1; ridx = 0; llb = mdl_llbit;
    for (int i = 0; i < 2; i++) begin
      if (sl[i].req) begin
        if (sl[i].sc && !llb) begin
          exp_stall += 1;
          exp_ok[i] = 1'b0;
        end else begin
          exp_stall += a_lat[ridx] + 1 + d_lat[ridx];
          t.addr = sl[i].addr; t.wr = |sl[i].wen; t.wstrb = sl[i].wen;
          t.size = sl[i].size; t.wdata = sl[i].wdata;
          exp_q.push_back(t);
          if (sl[i].wen == 4'h0) exp_rd[i] = rv_tab[ridx];
          exp_ok[i] = sl[i].sc;
`ifdef MEM_LLBIT_EN
          if (sl[i].sc) llb = 1'b0;
          else if (sl[i].ll) llb = 1'b1;
`endif
          ridx++;
        end
      end
    end
    mdl_llbit = llb;

    set_slots(p.m, p.s);
    stalls = 0;
    for (int c = 0; c < 100; c++) begin
      cycle();
      if (!obs_stall) break;
      stalls++;
    end
    set_slots('0, '0);

    check({name, "_stall"}, 128'(stalls), 128'(exp_stall));
    if (want >= 0) check({name, "_stall_spec"}, 128'(stalls), 128'(want));
    check({name, "_ntxn"}, 128'(txn_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < txn_q.size(); i++)
      check($sformatf("%s_txn%0d", name, i), 128'(txn_q[i]), 128'(exp_q[i]));
    check({name, "_m_rdata"}, 128'(m_rdata), 128'(exp_rd[0]));
    check({name, "_s_rdata"}, 128'(s_rdata), 128'(exp_rd[1]));
    check({name, "_sc_ok"}, 128'({m_sc_ok, s_sc_ok}), 128'({exp_ok[0], exp_ok[1]}));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pair_t p;
    slot_t rd;
    int    r;

    set_slots('0, '0);
    flush = 1'b0; llbit_clr = 1'b0; resetn = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    pending = 1'b0; bus_setup(0, 1, 32'h0);
    exp_rd[0] = '0; exp_rd[1] = '0; exp_ok[0] = 1'b0; exp_ok[1] = 1'b0;
`ifdef MEM_LLBIT_EN
    mdl_llbit = 1'b0;
`else
    mdl_llbit = 1'b1;
`endif
    rd = mk_slot(1'b1, 4'h0, 2'd2, 32'h0000_5000, 32'h0, 1'b0, 1'b0);

    // Directed pairs with spec-given stall counts.
    vecs[0] = '{p: mk_pair(mk_slot(1'b1, 4'h0, 2'd2, 32'h1000, 32'h0, 1'b0, 1'b0), '0,
                           4'd0, 4'd1, 4'd0, 4'd1, 32'hDEAD_BEEF, 32'h0), want: 8'd3};
    vecs[1] = '{p: mk_pair(mk_slot(1'b1, 4'hF, 2'd2, 32'h2000, 32'hCAFE_F00D, 1'b0, 1'b0),
                           mk_slot(1'b1, 4'h0, 2'd2, 32'h2004, 32'h0, 1'b0, 1'b0),
                           4'd0, 4'd1, 4'd0, 4'd1, 32'h1111_2222, 32'h0BAD_F00D), want: 8'd5};
    vecs[2] = '{p: mk_pair(mk_slot(1'b0, 4'hF, 2'd2, 32'hFFFF_0000, 32'h1111_1111, 1'b0, 1'b0),
                           mk_slot(1'b1, 4'b1000, 2'd0, 32'h3003, 32'h5500_0000, 1'b0, 1'b0),
                           4'd0, 4'd1, 4'd0, 4'd1, 32'h9999_9999, 32'h0), want: 8'd3};
    vecs[3] = '{p: mk_pair(mk_slot(1'b1, 4'h0, 2'd2, 32'h1010, 32'h0, 1'b0, 1'b0), '0,
                           4'd2, 4'd3, 4'd0, 4'd1, 32'h0102_0304, 32'h0), want: 8'd7};
    vecs[4] = '{p: mk_pair(mk_slot(1'b1, 4'h0, 2'd1, 32'h1022, 32'h0, 1'b0, 1'b0),
                           mk_slot(1'b1, 4'h0, 2'd0, 32'h1031, 32'h0, 1'b0, 1'b0),
                           4'd1, 4'd2, 4'd0, 4'd1, 32'hA0A0_0000, 32'h0000_00B1), want: 8'd7};
    vecs[5] = '{p: mk_pair(mk_slot(1'b1, 4'b0011, 2'd1, 32'h1040, 32'h0000_BEEF, 1'b0, 1'b0),
                           mk_slot(1'b1, 4'hF, 2'd2, 32'h1044, 32'h7654_3210, 1'b0, 1'b0),
                           4'd0, 4'd1, 4'd0, 4'd1, 32'hEEEE_EEEE, 32'hDDDD_DDDD), want: 8'd5};
    vecs[6] = '{p: mk_pair('0, mk_slot(1'b1, 4'h0, 2'd2, 32'h1050, 32'h0, 1'b0, 1'b0),
                           4'd3, 4'd2, 4'd0, 4'd1, 32'h600D_CAFE, 32'h0), want: 8'd7};

    repeat (2) @(negedge clk);
    check("rst_data_req", 128'(data_req), 128'(0));
    check("rst_rdata", 128'({m_rdata, s_rdata}), 128'(0));
    check("rst_sc_ok", 128'({m_sc_ok, s_sc_ok}), 128'(0));
    check("rst_stall_idle", 128'(mem_stall), 128'(0));
    m_req = 1'b1; #1;
    check("rst_stall_comb", 128'(mem_stall), 128'(1));
    m_req = 1'b0;
    @(negedge clk); resetn = 1'b1; @(negedge clk);

    for (int i = 0; i < 7; i++) run_pair(vecs[i].p, int'(vecs[i].want), $sformatf("vec%0d", i));

    // Flush while the request waits for addr_ok.
    bus_setup(20, 1, 32'h0);
    set_slots(mk_slot(1'b1, 4'h0, 2'd2, 32'h1000, 32'h0, 1'b0, 1'b0), '0);
    cycle(); cycle();
    check("fa_req_up", 128'(obs_req), 128'(1));
    cycle();
    flush = 1'b1; cycle();
    flush = 1'b0; set_slots('0, '0); cycle();
    check("fa_req_dropped", 128'(obs_req), 128'(0));
    check("fa_no_txn", 128'(txn_q.size()), 128'(0));
`ifdef MEM_LLBIT_EN
    mdl_llbit = 1'b0;
`endif
    run_pair(mk_pair(rd, '0, 4'd0, 4'd1, 4'd0, 4'd1, 32'h1357_9BDF, 32'h0), 3, "after_fa");

    // Flush in DATA: data_ok arrives 4 cycles later and is discarded.
    bus_setup(0, 5, 32'h1234_5678);
    set_slots(mk_slot(1'b1, 4'h0, 2'd2, 32'h1100, 32'h0, 1'b0, 1'b0), '0);
    cycle(); cycle();
    flush = 1'b1; cycle();
    flush = 1'b0; set_slots('0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("fd_wait%0d_req", i), 128'(obs_req), 128'(0));
    end
    cycle();
    check("fd_ntxn", 128'(txn_q.size()), 128'(1));
    check("fd_m_rdata_kept", 128'(m_rdata), 128'(exp_rd[0]));
    check("fd_s_rdata_kept", 128'(s_rdata), 128'(exp_rd[1]));
`ifdef MEM_LLBIT_EN
    mdl_llbit = 1'b0;
`endif
    run_pair(mk_pair(rd, '0, 4'd0, 4'd1, 4'd0, 4'd1, 32'h2468_ACE0, 32'h0), 3, "after_fd");

    // Flush coincides with addr_ok: accepted, then dropped.
    bus_setup(0, 2, 32'hA5A5_A5A5);
    set_slots(mk_slot(1'b1, 4'h0, 2'd2, 32'h1200, 32'h0, 1'b0, 1'b0), '0);
    cycle();
    flush = 1'b1; cycle();
    flush = 1'b0; set_slots('0, '0);
    cycle(); cycle();
    check("fx_ntxn", 128'(txn_q.size()), 128'(1));
    check("fx_m_rdata_kept", 128'(m_rdata), 128'(exp_rd[0]));
`ifdef MEM_LLBIT_EN
    mdl_llbit = 1'b0;
`endif
    run_pair(mk_pair(rd, '0, 4'd0, 4'd1, 4'd0, 4'd1, 32'h0F0F_0F0F, 32'h0), 3, "after_fx");

    // Asynchronous reset while a read is outstanding.
    bus_setup(0, 3, 32'h7777_7777);
    set_slots(rd, mk_slot(1'b1, 4'h0, 2'd2, 32'h1304, 32'h0, 1'b0, 1'b0));
    cycle(); cycle();
    #2 resetn = 1'b0; #1;
    check("mr_data_req", 128'(data_req), 128'(0));
    check("mr_stall_idle", 128'(mem_stall), 128'(1));
    check("mr_rdata", 128'({m_rdata, s_rdata}), 128'(0));
    pending = 1'b0; acnt = 0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_ok[0] = 1'b0; exp_ok[1] = 1'b0;
`ifdef MEM_LLBIT_EN
    mdl_llbit = 1'b0;
`endif
    set_slots('0, '0);
    @(negedge clk); resetn = 1'b1;
    run_pair(mk_pair(rd, '0, 4'd0, 4'd1, 4'd0, 4'd1, 32'hFACE_B00C, 32'h0), 3, "after_rst");

`ifdef MEM_LLBIT_EN
    run_pair(mk_pair(mk_slot(1'b1, 4'h0, 2'd2, 32'h4000, 32'h0, 1'b1, 1'b0), '0,
                     4'd0, 4'd1, 4'd0, 4'd1, 32'h0000_0042, 32'h0), 3, "ll1");
    run_pair(mk_pair(mk_slot(1'b1, 4'hF, 2'd2, 32'h4000, 32'h0000_0043, 1'b0, 1'b1), '0,
                     4'd0, 4'd1, 4'd0, 4'd1, 32'h0, 32'h0), 3, "sc_ok");
    check("sc_ok_flag", 128'(m_sc_ok), 128'(1));
    run_pair(mk_pair(mk_slot(1'b1, 4'h0, 2'd2, 32'h4000, 32'h0, 1'b1, 1'b0), '0,
                     4'd0, 4'd1, 4'd0, 4'd1, 32'h0000_0044, 32'h0), 3, "ll2");
    llbit_clr = 1'b1; cycle(); llbit_clr = 1'b0;
    mdl_llbit = 1'b0;
    run_pair(mk_pair(mk_slot(1'b1, 4'hF, 2'd2, 32'h4000, 32'h0000_0045, 1'b0, 1'b1), '0,
                     4'd0, 4'd1, 4'd0, 4'd1, 32'h0, 32'h0), 2, "sc_fail");
    check("sc_fail_flag", 128'(m_sc_ok), 128'(0));
    check("sc_fail_no_txn", 128'(txn_q.size()), 128'(0));
`endif

    // Randomised pairs.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(1, 3);
      p = mk_pair(rnd_slot(r[0]), rnd_slot(r[1]),
                  4'($urandom_range(0, 3)), 4'($urandom_range(1, 3)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(1, 3)), $urandom, $urandom);
      run_pair(p, -1, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
